// File: rtl/inst_fetch_queue_pkg.sv
// Shared types for the fetch-to-decode instruction queue.
package inst_fetch_queue_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] target;
  } bpu_predict_t;

  // slot1 marks which fetch slot produced the entry, for BPU correction.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    bpu_predict_t    predict;
    logic            slot1;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_queue.sv
// Dual-wide decoupling FIFO between fetch and decode: compacts partial pairs
// into program order and presents the two oldest entries first-word-fall-through.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic [1:0]                f_valid_i,
  input  logic [1:0][XLEN-1:0]      f_pc_i,
  input  logic [1:0][XLEN-1:0]      f_inst_i,
  input  bpu_predict_t              f_predict_i,
  output logic                      f_stall_o,
  output logic [1:0]                d_valid_o,
  output fetch_entry_t [1:0]        d_entry_o,
  input  logic [1:0]                d_accept_i,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  rptr;
  logic [PW-1:0]  wptr;
  logic [AW-1:0]  widx0;
  logic [AW-1:0]  widx1;
  logic [AW-1:0]  ridx0;
  logic [AW-1:0]  ridx1;
  logic [1:0]     n_enq;
  logic [1:0]     n_deq;
  logic           enq;
  fetch_entry_t   wr_slot0;
  fetch_entry_t   wr_slot1;

  assign count_o = wptr - rptr;

  // Stall is taken from registered occupancy only, so a pair always fits.
  assign f_stall_o = count_o > PW'(DEPTH - 2);
  assign enq       = !f_stall_o && !flush_i && !rst;

  assign n_enq = {1'b0, f_valid_i[0]} + {1'b0, f_valid_i[1]};
  assign n_deq = {1'b0, d_accept_i[0]} + {1'b0, d_accept_i[1]};

  assign widx0 = wptr[AW-1:0];
  assign widx1 = widx0 + AW'(1);
  assign ridx0 = rptr[AW-1:0];
  assign ridx1 = ridx0 + AW'(1);

  always_comb begin
    wr_slot0.pc      = f_pc_i[0];
    wr_slot0.inst    = f_inst_i[0];
    wr_slot0.predict = f_predict_i;
    wr_slot0.slot1   = 1'b0;
    wr_slot1.pc      = f_pc_i[1];
    wr_slot1.inst    = f_inst_i[1];
    wr_slot1.predict = f_predict_i;
    wr_slot1.slot1   = 1'b1;
  end

  // A lone slot1 instruction is compacted down to the write pointer.
  always_ff @(posedge clk) begin
    if (enq) begin
      case (f_valid_i)
        2'b11: begin
          mem[widx0] <= wr_slot0;
          mem[widx1] <= wr_slot1;
        end
        2'b01:   mem[widx0] <= wr_slot0;
        2'b10:   mem[widx0] <= wr_slot1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rptr <= '0;
      wptr <= '0;
    end else begin
      if (enq) wptr <= wptr + PW'(n_enq);
      rptr <= rptr + PW'(n_deq);
    end
  end

  assign d_entry_o[0] = mem[ridx0];
  assign d_entry_o[1] = mem[ridx1];

  always_comb begin
    d_valid_o = 2'b00;
    if (count_o >= PW'(2))      d_valid_o = 2'b11;
    else if (count_o == PW'(1)) d_valid_o = 2'b01;
  end

  a_accept_legal: assert property (@(posedge clk) disable iff (rst)
    (d_accept_i != 2'b10) && ((d_accept_i & ~d_valid_o) == 2'b00));

  a_no_overfill: assert property (@(posedge clk) disable iff (rst)
    !(enq && (f_valid_i != 2'b00) && (count_o > PW'(DEPTH - 2))));

  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    count_o <= PW'(DEPTH));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: entries are queued when fetch is
// driven and compared at the head of the DUT while they are visible.
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  localparam int DEPTH = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush_i;
  logic [1:0]            f_valid_i;
  logic [1:0][XLEN-1:0]  f_pc_i;
  logic [1:0][XLEN-1:0]  f_inst_i;
  bpu_predict_t          f_predict_i;
  logic                  f_stall_o;
  logic [1:0]            d_valid_o;
  fetch_entry_t [1:0]    d_entry_o;
  logic [1:0]            d_accept_i;
  logic [$clog2(DEPTH):0] count_o;

  fetch_entry_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .f_valid_i   (f_valid_i),
    .f_pc_i      (f_pc_i),
    .f_inst_i    (f_inst_i),
    .f_predict_i (f_predict_i),
    .f_stall_o   (f_stall_o),
    .d_valid_o   (d_valid_o),
    .d_entry_o   (d_entry_o),
    .d_accept_i  (d_accept_i),
    .count_o     (count_o)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic fetch_entry_t mk(input logic [31:0] pc, input logic s1, input bpu_predict_t p);
    fetch_entry_t e;
    e.pc      = pc;
    e.inst    = pc ^ 32'ha5a5_0000 ^ {31'b0, s1};
    e.predict = p;
    e.slot1   = s1;
    return e;
  endfunction

  // Called at a negedge: checks head state, drives one cycle, updates the model.
  task automatic step(input logic [1:0] fv, input logic [31:0] base,
                      input logic [1:0] acc, input logic fl);
    logic [1:0]   a;
    logic         stalled;
    logic [1:0]   exp_valid;
    fetch_entry_t e0, e1;
    bpu_predict_t p;
    exp_valid = (sb.size() >= 2) ? 2'b11 : (sb.size() == 1) ? 2'b01 : 2'b00;
    stalled   = (sb.size() >= DEPTH - 1);
    check("count", 128'(count_o), 128'(sb.size()));
    check("stall", 128'(f_stall_o), 128'(stalled));
    check("d_valid", 128'(d_valid_o), 128'(exp_valid));
    if (sb.size() >= 1) check("head0", 128'(d_entry_o[0]), 128'(sb[0]));
    if (sb.size() >= 2) check("head1", 128'(d_entry_o[1]), 128'(sb[1]));
    a = (acc == 2'b10) ? 2'b01 : acc;
    a = a & exp_valid;
    p.taken  = 1'($urandom);
    p.target = $urandom;
    e0 = mk(base, 1'b0, p);
    e1 = mk(base + 32'd4, 1'b1, p);
    f_valid_i   = fv;
    f_pc_i[0]   = e0.pc;
    f_pc_i[1]   = e1.pc;
    f_inst_i[0] = e0.inst;
    f_inst_i[1] = e1.inst;
    f_predict_i = p;
    d_accept_i  = a;
    flush_i     = fl;
    @(posedge clk);
    if (fl) begin
      sb.delete();
    end else begin
      if (a[0]) void'(sb.pop_front());
      if (a[1]) void'(sb.pop_front());
      if (!stalled) begin
        if (fv[0]) sb.push_back(e0);
        if (fv[1]) sb.push_back(e1);
      end
    end
    @(negedge clk);
    f_valid_i  = 2'b00;
    d_accept_i = 2'b00;
    flush_i    = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH; i++) step(2'b00, 32'h0, 2'b11, 1'b0);
  endtask

  initial begin
    logic [31:0] pc;
    logic [1:0]  fv;
    logic [1:0]  acc;
    rst         = 1'b1;
    flush_i     = 1'b0;
    f_valid_i   = 2'b00;
    f_pc_i      = '0;
    f_inst_i    = '0;
    f_predict_i = '0;
    d_accept_i  = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state, then a full pair
    step(2'b00, 32'h0, 2'b00, 1'b0);
    step(2'b11, 32'h1c00_0000, 2'b00, 1'b0);
    check("t1_pc0", 128'(d_entry_o[0].pc), 128'(32'h1c00_0000));
    check("t1_pc1", 128'(d_entry_o[1].pc), 128'(32'h1c00_0004));
    step(2'b00, 32'h0, 2'b00, 1'b0);
    drain();

    // Lone slot1 instruction compacted to head
    step(2'b10, 32'h1c00_0000, 2'b00, 1'b0);
    check("t2_pc", 128'(d_entry_o[0].pc), 128'(32'h1c00_0004));
    check("t2_slot1", 128'(d_entry_o[0].slot1), 128'(1'b1));
    step(2'b00, 32'h0, 2'b01, 1'b0);

    // Fill to full, attempt ignored writes, stall at DEPTH-1
    pc = 32'h2000_0000;
    for (int i = 0; i < 4; i++) begin
      step(2'b11, pc, 2'b00, 1'b0);
      pc += 32'd8;
    end
    step(2'b11, pc, 2'b00, 1'b0);
    step(2'b11, pc + 32'd8, 2'b01, 1'b0);
    step(2'b11, pc + 32'd16, 2'b00, 1'b0);
    drain();

    // Simultaneous enqueue and dequeue at count 4
    pc = 32'h3000_0000;
    step(2'b11, pc, 2'b00, 1'b0);
    step(2'b11, pc + 32'd8, 2'b00, 1'b0);
    step(2'b11, pc + 32'd16, 2'b11, 1'b0);
    step(2'b00, 32'h0, 2'b00, 1'b0);
    drain();

    // Random fill/drain crossing the index wrap several times
    pc = 32'h4000_0000;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 2))
        0:       fv = 2'b01;
        1:       fv = 2'b10;
        default: fv = 2'b11;
      endcase
      case ($urandom_range(0, 2))
        0:       acc = 2'b00;
        1:       acc = 2'b01;
        default: acc = 2'b11;
      endcase
      step(fv, pc, acc, 1'b0);
      pc += 32'd8;
    end
    drain();

    // Flush at count 5 together with a pair
    pc = 32'h5000_0000;
    step(2'b11, pc, 2'b00, 1'b0);
    step(2'b11, pc + 32'd8, 2'b00, 1'b0);
    step(2'b01, pc + 32'd16, 2'b00, 1'b0);
    check("t6_precount", 128'(count_o), 128'(5));
    step(2'b11, 32'hdead_0000, 2'b00, 1'b1);
    check("t6_count", 128'(count_o), 128'(0));
    check("t6_valid", 128'(d_valid_o), 128'(2'b00));
    step(2'b11, 32'h6000_0000, 2'b00, 1'b0);
    check("t6_newhead", 128'(d_entry_o[0].pc), 128'(32'h6000_0000));
    drain();

    // Reset mid-operation with fetch valid
    step(2'b11, 32'h7000_0000, 2'b00, 1'b0);
    step(2'b11, 32'h7000_0008, 2'b00, 1'b0);
    rst       = 1'b1;
    f_valid_i = 2'b11;
    @(posedge clk);
    sb.delete();
    @(negedge clk);
    rst       = 1'b0;
    f_valid_i = 2'b00;
    step(2'b00, 32'h0, 2'b00, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
